// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore FSM that sequences each instruction
// over several cycles. It stalls on the memory ready handshake and holds
// EXECUTE for a parametrised number of cycles on a multiply.
module mips_multicycle_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int ALUCTRL_W   = 3,
    parameter int STATE_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 iord,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [1:0]           pc_src,
    output logic                 pc_en,
    output logic                 illegal_op,
    output logic [STATE_W-1:0]   state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011100;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b000);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3'b001);
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b010);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b100);
    localparam logic [ALUCTRL_W-1:0] ALU_MUL = ALUCTRL_W'(3'b101);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(3'b110);

    // Purely state-decoded outputs, kept together so they register as one word.
    typedef struct packed {
        logic                 mem_req;
        logic                 iord;
        logic                 mem_write;
        logic                 reg_dst;
        logic                 mem_to_reg;
        logic                 reg_write;
        logic                 alu_src_a;
        logic [1:0]           alu_src_b;
        logic [ALUCTRL_W-1:0] alu_control;
        logic [1:0]           pc_src;
    } moore_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] mul_cnt;
    logic [3:0] cnt_nxt;
    moore_t     mo_r;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       op_legal;
    logic       funct_legal;
    logic       unused_instr;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign unused_instr = ^instr[25:6];

    assign op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                      (opcode == OP_BEQ)   || (opcode == OP_ADDI) || (opcode == OP_J);
    assign funct_legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT) ||
                         (funct == FN_MUL) || (funct == FN_AND) || (funct == FN_OR);

    function automatic logic [ALUCTRL_W-1:0] alu_from_funct(input logic [5:0] f);
        case (f)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_SLT:  return ALU_SLT;
            FN_MUL:  return ALU_MUL;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic moore_t moore_decode(input state_t s, input logic [5:0] f);
        moore_t m;
        m             = '0;
        m.alu_control = ALU_ADD;
        case (s)
            S_FETCH: begin
                m.mem_req   = 1'b1;
                m.alu_src_b = 2'b01;
            end
            S_DECODE: m.alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                m.mem_req = 1'b1;
                m.iord    = 1'b1;
            end
            S_MEMWB: begin
                m.reg_write  = 1'b1;
                m.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                m.mem_req   = 1'b1;
                m.iord      = 1'b1;
                m.mem_write = 1'b1;
            end
            S_EXEC: begin
                m.alu_src_a   = 1'b1;
                m.alu_control = alu_from_funct(f);
            end
            S_ALUWB: begin
                m.reg_write = 1'b1;
                m.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                m.alu_src_a   = 1'b1;
                m.alu_control = ALU_SUB;
                m.pc_src      = 2'b01;
            end
            S_ADDIWB: m.reg_write = 1'b1;
            S_JUMP:   m.pc_src    = 2'b10;
            default:  m.mem_req   = 1'b0;
        endcase
        return m;
    endfunction

    // Next-state and multiply-counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = mul_cnt;
        case (state)
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE: begin
                        state_nxt = S_EXEC;
                        if (funct == FN_MUL) cnt_nxt = 4'(MUL_LATENCY);
                    end
                    OP_BEQ:  state_nxt = S_BRANCH;
                    OP_ADDI: state_nxt = S_ADDIEX;
                    OP_J:    state_nxt = S_JUMP;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
            S_EXEC: begin
                if (!funct_legal) begin
                    state_nxt = S_FETCH;
                end else if (funct == FN_MUL) begin
                    // Counter holds the cycles left in EXEC, including this one.
                    if (mul_cnt <= 4'd1) state_nxt = S_ALUWB;
                    else                 cnt_nxt   = mul_cnt - 4'd1;
                end else begin
                    state_nxt = S_ALUWB;
                end
            end
            S_ADDIEX: state_nxt = S_ADDIWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // State register; Moore outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            mul_cnt <= '0;
            mo_r    <= moore_decode(S_FETCH, funct);
        end else begin
            state   <= state_nxt;
            mul_cnt <= cnt_nxt;
            mo_r    <= moore_decode(state_nxt, funct);
        end
    end

    // Strobes are gated by reset so nothing writes while rst_n is low.
    assign mem_req     = rst_n & mo_r.mem_req;
    assign mem_write   = rst_n & mo_r.mem_write;
    assign reg_write   = rst_n & mo_r.reg_write;
    assign iord        = mo_r.iord;
    assign reg_dst     = mo_r.reg_dst;
    assign mem_to_reg  = mo_r.mem_to_reg;
    assign alu_src_a   = mo_r.alu_src_a;
    assign alu_src_b   = mo_r.alu_src_b;
    assign alu_control = mo_r.alu_control;
    assign pc_src      = mo_r.pc_src;

    assign ir_write   = rst_n & (state == S_FETCH) & mem_ready;
    assign pc_en      = rst_n & (((state == S_FETCH) & mem_ready) |
                                 ((state == S_BRANCH) & zero) |
                                 (state == S_JUMP));
    assign illegal_op = rst_n & (((state == S_DECODE) & !op_legal) |
                                 ((state == S_EXEC) & !funct_legal));
    assign state_o    = STATE_W'(state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: two instances (multiply latency 4 and 1)
// are compared cycle by cycle against per-instruction phase traces.
module tb_mips_multicycle_ctrl;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                   P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_ADDIEX = 9,
                   P_ADDIWB = 10, P_JUMP = 11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] instr = 32'h0;

    logic       mem_req_a, iord_a, mem_write_a, ir_write_a, reg_dst_a, mem_to_reg_a;
    logic       reg_write_a, alu_src_a_a, pc_en_a, illegal_op_a;
    logic [1:0] alu_src_b_a, pc_src_a;
    logic [2:0] alu_control_a;
    logic [3:0] state_o_a;
    logic       mem_req_b, iord_b, mem_write_b, ir_write_b, reg_dst_b, mem_to_reg_b;
    logic       reg_write_b, alu_src_a_b, pc_en_b, illegal_op_b;
    logic [1:0] alu_src_b_b, pc_src_b;
    logic [2:0] alu_control_b;
    logic [3:0] state_o_b;

    logic [20:0] act_a, act_b;

    int errors = 0;
    int checks = 0;
    int cnt_exec_a, cnt_exec_b, cnt_memrd_a;

    typedef struct {
        int ph;
        bit mr;
    } step_t;
    step_t ta[$];
    step_t tqb[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MUL_LATENCY(4), .ALUCTRL_W(3), .STATE_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req_a), .iord(iord_a), .mem_write(mem_write_a), .ir_write(ir_write_a),
        .reg_dst(reg_dst_a), .mem_to_reg(mem_to_reg_a), .reg_write(reg_write_a),
        .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a), .alu_control(alu_control_a),
        .pc_src(pc_src_a), .pc_en(pc_en_a), .illegal_op(illegal_op_a), .state_o(state_o_a)
    );

    mips_multicycle_ctrl #(.MUL_LATENCY(1), .ALUCTRL_W(3), .STATE_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req_b), .iord(iord_b), .mem_write(mem_write_b), .ir_write(ir_write_b),
        .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b),
        .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_control(alu_control_b),
        .pc_src(pc_src_b), .pc_en(pc_en_b), .illegal_op(illegal_op_b), .state_o(state_o_b)
    );

    assign act_a = {state_o_a, mem_req_a, iord_a, mem_write_a, ir_write_a, reg_dst_a,
                    mem_to_reg_a, reg_write_a, alu_src_a_a, alu_src_b_a, alu_control_a,
                    pc_src_a, pc_en_a, illegal_op_a};
    assign act_b = {state_o_b, mem_req_b, iord_b, mem_write_b, ir_write_b, reg_dst_b,
                    mem_to_reg_b, reg_write_b, alu_src_a_b, alu_src_b_b, alu_control_b,
                    pc_src_b, pc_en_b, illegal_op_b};

    // {valid, alu code} for an R-type funct
    function automatic logic [3:0] f_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b1010;
            6'b100010: return 4'b1100;
            6'b101010: return 4'b1110;
            6'b011100: return 4'b1101;
            6'b100100: return 4'b1000;
            6'b100101: return 4'b1001;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic bit op_known(input logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
               (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
    endfunction

    // Expected output word for a phase, taken from the per-state output table.
    function automatic logic [20:0] exp_vec(input int ph, input logic [31:0] ins,
                                            input logic mr, input logic z);
        logic mreq, io, mw, irw, rd, m2r, rw, sa, pce, ill;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        logic [3:0] fa;
        mreq = 0; io = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0; pce = 0; ill = 0;
        sb = 2'b00; ps = 2'b00; ac = 3'b010;
        fa = f_alu(ins[5:0]);
        case (ph)
            P_FETCH:  begin mreq = 1; sb = 2'b01; irw = mr; pce = mr; end
            P_DECODE: begin sb = 2'b11; ill = !op_known(ins[31:26]); end
            P_MEMADR: begin sa = 1; sb = 2'b10; end
            P_MEMRD:  begin mreq = 1; io = 1; end
            P_MEMWB:  begin rw = 1; m2r = 1; end
            P_MEMWR:  begin mreq = 1; io = 1; mw = 1; end
            P_EXEC:   begin sa = 1; if (fa[3]) ac = fa[2:0]; else ill = 1; end
            P_ALUWB:  begin rw = 1; rd = 1; end
            P_BRANCH: begin sa = 1; ac = 3'b100; ps = 2'b01; pce = z; end
            P_ADDIEX: begin sa = 1; sb = 2'b10; end
            P_ADDIWB: rw = 1;
            P_JUMP:   begin ps = 2'b10; pce = 1; end
            default:  ill = 0;
        endcase
        return {4'(ph), mreq, io, mw, irw, rd, m2r, rw, sa, sb, ac, ps, pce, ill};
    endfunction

    // Phase sequence one instruction walks through, with the mem_ready to drive at each step.
    task automatic build(input logic [31:0] ins, input int fw, input int mw,
                         input int lat, input bit to_b);
        step_t q[$];
        logic [5:0] op;
        logic [3:0] fa;
        op = ins[31:26];
        fa = f_alu(ins[5:0]);
        for (int k = 0; k <= fw; k++) q.push_back('{P_FETCH, k == fw});
        q.push_back('{P_DECODE, 1'($urandom)});
        case (op)
            6'b100011: begin
                q.push_back('{P_MEMADR, 1'($urandom)});
                for (int k = 0; k <= mw; k++) q.push_back('{P_MEMRD, k == mw});
                q.push_back('{P_MEMWB, 1'($urandom)});
            end
            6'b101011: begin
                q.push_back('{P_MEMADR, 1'($urandom)});
                for (int k = 0; k <= mw; k++) q.push_back('{P_MEMWR, k == mw});
            end
            6'b000000: begin
                if (fa[3]) begin
                    for (int k = 0; k < ((ins[5:0] == 6'b011100) ? lat : 1); k++)
                        q.push_back('{P_EXEC, 1'($urandom)});
                    q.push_back('{P_ALUWB, 1'($urandom)});
                end else begin
                    q.push_back('{P_EXEC, 1'($urandom)});
                end
            end
            6'b000100: q.push_back('{P_BRANCH, 1'($urandom)});
            6'b001000: begin
                q.push_back('{P_ADDIEX, 1'($urandom)});
                q.push_back('{P_ADDIWB, 1'($urandom)});
            end
            6'b000010: q.push_back('{P_JUMP, 1'($urandom)});
            default: ;
        endcase
        if (to_b) tqb = q;
        else      ta  = q;
    endtask

    // Runs one instruction from FETCH back to FETCH, comparing every cycle.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic z, input bit chk_b);
        logic [20:0] ev;
        build(ins, fw, mw, 4, 1'b0);
        build(ins, fw, mw, 1, 1'b1);
        cnt_exec_a = 0; cnt_exec_b = 0; cnt_memrd_a = 0;
        instr = ins;
        zero  = z;
        for (int i = 0; i < ta.size(); i++) begin
            mem_ready = ta[i].mr;
            @(negedge clk);
            ev = exp_vec(ta[i].ph, ins, mem_ready, z);
            checks++;
            if (act_a !== ev) begin
                errors++;
                $display("FAIL trace_lat4 instr=%h step=%0d: got %h expected %h", ins, i, act_a, ev);
            end
            if (chk_b && i < tqb.size()) begin
                ev = exp_vec(tqb[i].ph, ins, mem_ready, z);
                checks++;
                if (act_b !== ev) begin
                    errors++;
                    $display("FAIL trace_lat1 instr=%h step=%0d: got %h expected %h", ins, i, act_b, ev);
                end
                if (state_o_b == 4'd6) cnt_exec_b++;
            end
            if (state_o_a == 4'd6) cnt_exec_a++;
            if (state_o_a == 4'd3) cnt_memrd_a++;
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({mem_req_a, mem_write_a, ir_write_a, reg_write_a, pc_en_a, illegal_op_a,
                 mem_req_b, mem_write_b, ir_write_b, reg_write_b, pc_en_b, illegal_op_b} !== 12'h0) begin
                errors++;
                $display("FAIL reset_strobes cycle=%0d: got a=%b%b%b%b%b%b b=%b%b%b%b%b%b expected all 0", c,
                         mem_req_a, mem_write_a, ir_write_a, reg_write_a, pc_en_a, illegal_op_a,
                         mem_req_b, mem_write_b, ir_write_b, reg_write_b, pc_en_b, illegal_op_b);
            end
            if (c == 1) begin
                checks++;
                if (state_o_a !== 4'd0 || state_o_b !== 4'd0) begin
                    errors++;
                    $display("FAIL reset_state: got a=%0d b=%0d expected 0", state_o_a, state_o_b);
                end
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 12);
        case (k)
            0: w[31:26] = 6'b100011;
            1: w[31:26] = 6'b101011;
            2: begin w[31:26] = 6'b000000; w[5:0] = 6'b100000; end
            3: begin w[31:26] = 6'b000000; w[5:0] = 6'b100010; end
            4: begin w[31:26] = 6'b000000; w[5:0] = 6'b101010; end
            5: begin w[31:26] = 6'b000000; w[5:0] = 6'b011100; end
            6: begin w[31:26] = 6'b000000; w[5:0] = 6'b100100; end
            7: begin w[31:26] = 6'b000000; w[5:0] = 6'b100101; end
            8: w[31:26] = 6'b000100;
            9: w[31:26] = 6'b001000;
            10: w[31:26] = 6'b000010;
            11: w[31:29] = 3'b111;
            default: begin w[31:26] = 6'b000000; w[5:4] = 2'b00; end
        endcase
        return w;
    endfunction

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_add();
        apply_reset();
        run_instr(32'h012A4020, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_lw_stall();
        apply_reset();
        run_instr(32'h8D090004, 0, 3, 1'b0, 1'b1);
        checks++;
        if (cnt_memrd_a != 4) begin
            errors++;
            $display("FAIL lw_memrd_cycles: got %0d expected 4", cnt_memrd_a);
        end
    endtask

    task automatic test_mul();
        apply_reset();
        run_instr(32'h012A401C, 0, 0, 1'b0, 1'b1);
        checks++;
        if (cnt_exec_a != 4) begin
            errors++;
            $display("FAIL mul_lat4_exec_cycles: got %0d expected 4", cnt_exec_a);
        end
        checks++;
        if (cnt_exec_b != 1) begin
            errors++;
            $display("FAIL mul_lat1_exec_cycles: got %0d expected 1", cnt_exec_b);
        end
    endtask

    task automatic test_beq();
        apply_reset();
        run_instr(32'h11090003, 0, 0, 1'b1, 1'b1);
        run_instr(32'h11090003, 1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_sw_addi_j();
        apply_reset();
        run_instr(32'hAD090008, 2, 2, 1'b0, 1'b1);
        run_instr(32'h21090005, 0, 0, 1'b0, 1'b1);
        run_instr(32'h08000010, 0, 0, 1'b1, 1'b1);
    endtask

    task automatic test_illegal();
        apply_reset();
        run_instr(32'hFC000000, 0, 0, 1'b0, 1'b1);
        run_instr(32'h012A4001, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midstall();
        apply_reset();
        instr = 32'h8D090004;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (state_o_a !== 4'd3 || mem_req_a !== 1'b1 || iord_a !== 1'b1) begin
            errors++;
            $display("FAIL midstall_in_memrd: got state=%0d mem_req=%b iord=%b expected 3 1 1",
                     state_o_a, mem_req_a, iord_a);
        end
        @(posedge clk); #1;
        apply_reset();
        @(negedge clk);
        checks++;
        if (state_o_a !== 4'd0 || mem_req_a !== 1'b1 || iord_a !== 1'b0) begin
            errors++;
            $display("FAIL release_fetch: got state=%0d mem_req=%b iord=%b expected 0 1 0",
                     state_o_a, mem_req_a, iord_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int n = 0; n < 60; n++)
            run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom), 1'b0);
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_lw_stall();
        test_mul();
        test_beq();
        test_sw_addi_j();
        test_illegal();
        test_reset_midstall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
